mem_shim_mc: RTL and testbench

MEM_SHIM_MC -- requirements
Module: mem_shim_mc

---
 rtl/mem_shim_mc.sv | 168 ++++++++++++++++
 tb/tb_mem_shim_mc.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_shim_mc.sv
// mem_shim_mc: round-robin multi-channel bridge from core request FIFOs to an Avalon-MM DDR3 master,
// with in-order read response routing via a channel tag FIFO.
module mem_shim_mc #(
    parameter int NCH = 2,
    parameter int ADDR_W = 22,
    parameter int DATA_W = 64,
    parameter int DDR_AW = 29,
    parameter logic [DDR_AW-ADDR_W-1:0] BASE_HI = 7'b0011000,
    parameter int MAX_OUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hard_rst,
    input  logic [2*NCH-1:0]           mem_req_rd_cmd,
    input  logic [ADDR_W*NCH-1:0]      mem_req_rd_addr,
    input  logic [DATA_W*NCH-1:0]      mem_req_rd_dta,
    input  logic [NCH-1:0]             mem_req_rd_valid,
    output logic [NCH-1:0]             mem_req_rd_en,
    output logic [DATA_W-1:0]          mem_res_wr_dta,
    output logic [NCH-1:0]             mem_res_wr_en,
    input  logic [NCH-1:0]             mem_res_wr_almost_full,
    output logic [DDR_AW-1:0]          ddr3_addr,
    output logic [7:0]                 ddr3_burstcnt,
    output logic                       ddr3_read,
    output logic                       ddr3_write,
    output logic [DATA_W-1:0]          ddr3_writedata,
    output logic [DATA_W/8-1:0]        ddr3_byteenable,
    input  logic [DATA_W-1:0]          ddr3_readdata,
    input  logic                       ddr3_readdatavalid,
    input  logic                       ddr3_waitrequest,
    output logic                       err_unexpected,
    output logic [$clog2(MAX_OUT):0]   outstanding
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int PW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam logic [OW-1:0] MAX_V = OW'(MAX_OUT);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state_q, state_d;
    logic [NCH-1:0] rd_en_q, rd_en_d, res_en_q, res_en_d, elig;
    logic [CW-1:0] gnt_q, gnt_d, ptr_q, ptr_d;
    logic rd_q, rd_d, wr_q, wr_d, err_q, err_d, push, pop, found;
    logic [DDR_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, res_dta_q, res_dta_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] tags_q [MAX_OUT];
    logic [CW-1:0] tags_d [MAX_OUT];
    logic [1:0] cmd_g;
    int idx;
    // Writes wait for an empty read pipeline so responses never pass a later write.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++)
            elig[i] = mem_req_rd_valid[i] && (mem_req_rd_cmd[2*i+1]
                ? (mem_req_rd_cmd[2*i] ? cnt_q == '0 : !mem_res_wr_almost_full[i] && cnt_q < MAX_V)
                : 1'b1);
    end
    always_comb begin
        found = 1'b0;
        idx = 0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && elig[(int'(ptr_q) + i) % NCH]) begin
                found = 1'b1;
                idx = (int'(ptr_q) + i) % NCH;
            end
        end
    end
    // A grant raises rd_en for one cycle; the show-ahead head is captured during that cycle.
    always_comb begin
        state_d = state_q;
        rd_en_d = '0;
        res_en_d = '0;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        rd_d = rd_q;
        wr_d = wr_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        res_dta_d = res_dta_q;
        err_d = err_q;
        wp_d = wp_q;
        rp_d = rp_q;
        tags_d = tags_q;
        cmd_g = mem_req_rd_cmd[2*gnt_q +: 2];
        push = rd_q && !ddr3_waitrequest;
        pop = ddr3_readdatavalid && cnt_q != '0;
        if (state_q == IDLE && rd_en_q == '0 && found) begin
            rd_en_d[idx] = 1'b1;
            gnt_d = CW'(idx);
            ptr_d = idx == NCH - 1 ? '0 : CW'(idx + 1);
        end
        if (state_q == IDLE && rd_en_q != '0) begin
            state_d = cmd_g[1] ? ISSUE : IDLE;
            rd_d = cmd_g == 2'd2;
            wr_d = cmd_g == 2'd3;
            addr_d = cmd_g[1] ? {BASE_HI, mem_req_rd_addr[ADDR_W*gnt_q +: ADDR_W]} : addr_q;
            wdata_d = cmd_g[1] ? mem_req_rd_dta[DATA_W*gnt_q +: DATA_W] : wdata_q;
        end
        if (state_q == ISSUE && !ddr3_waitrequest) begin
            state_d = IDLE;
            rd_d = 1'b0;
            wr_d = 1'b0;
        end
        if (ddr3_readdatavalid && cnt_q == '0)
            err_d = 1'b1;
        if (pop) begin
            res_en_d[tags_q[rp_q]] = 1'b1;
            res_dta_d = ddr3_readdata;
            rp_d = rp_q == PW'(MAX_OUT - 1) ? '0 : rp_q + PW'(1);
        end
        if (push) begin
            tags_d[wp_q] = gnt_q;
            wp_d = wp_q == PW'(MAX_OUT - 1) ? '0 : wp_q + PW'(1);
        end
        cnt_d = cnt_q + OW'(push) - OW'(pop);
    end
    // Read bookkeeping survives soft reset so in-flight responses still find their channel.
    always_ff @(posedge clk) begin
        if (rst || hard_rst) begin
            state_q <= IDLE;
            rd_en_q <= '0;
            res_en_q <= '0;
            gnt_q <= '0;
            ptr_q <= '0;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            res_dta_q <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            res_en_q <= res_en_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            res_dta_q <= res_dta_d;
        end
        if (hard_rst) begin
            cnt_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
            err_q <= 1'b0;
            tags_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            err_q <= err_d;
            tags_q <= tags_d;
        end
    end
    assign mem_req_rd_en = rd_en_q;
    assign mem_res_wr_en = res_en_q;
    assign mem_res_wr_dta = res_dta_q;
    assign ddr3_addr = addr_q;
    assign ddr3_burstcnt = 8'd1;
    assign ddr3_read = rd_q;
    assign ddr3_write = wr_q;
    assign ddr3_writedata = wdata_q;
    assign ddr3_byteenable = '1;
    assign err_unexpected = err_q;
    assign outstanding = cnt_q;
endmodule

// File: tb/tb_mem_shim_mc.sv
// tb_mem_shim_mc: directed scenario tests for mem_shim_mc with default parameters.
module tb_mem_shim_mc;
    logic clk = 1'b0;
    logic rst, hard_rst;
    logic [3:0] cmd;
    logic [43:0] addr;
    logic [127:0] dta;
    logic [1:0] valid, rd_en, res_en, af;
    logic [63:0] res_dta, wdata, rdata;
    logic [28:0] daddr;
    logic [7:0] burst, be;
    logic dread, dwrite, rdv, wreq, err;
    logic [3:0] outs;
    int nc = 0, nm = 0;
    int wr_acc = 0, rd_acc = 0, gr_n = 0;
    int pops [2] = '{0, 0};
    int gr_log [256];

    mem_shim_mc dut (
        .clk(clk), .rst(rst), .hard_rst(hard_rst),
        .mem_req_rd_cmd(cmd), .mem_req_rd_addr(addr), .mem_req_rd_dta(dta),
        .mem_req_rd_valid(valid), .mem_req_rd_en(rd_en),
        .mem_res_wr_dta(res_dta), .mem_res_wr_en(res_en), .mem_res_wr_almost_full(af),
        .ddr3_addr(daddr), .ddr3_burstcnt(burst), .ddr3_read(dread), .ddr3_write(dwrite),
        .ddr3_writedata(wdata), .ddr3_byteenable(be), .ddr3_readdata(rdata),
        .ddr3_readdatavalid(rdv), .ddr3_waitrequest(wreq),
        .err_unexpected(err), .outstanding(outs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dwrite && !wreq) wr_acc++;
        if (dread && !wreq) rd_acc++;
        for (int c = 0; c < 2; c++)
            if (rd_en[c]) begin
                pops[c]++;
                if (gr_n < 256) gr_log[gr_n] = c;
                gr_n++;
            end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [1:0] cm, input logic [21:0] a, input logic [63:0] d);
        cmd[2*c +: 2] = cm;
        addr[22*c +: 22] = a;
        dta[64*c +: 64] = d;
        valid[c] = 1'b1;
    endtask

    task automatic wait_en(input int c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rd_en[c]) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; hard_rst = 1'b1; cmd = '0; addr = '0; dta = '0; valid = '0; af = '0;
        rdata = '0; rdv = 1'b0; wreq = 1'b0;
        tick; tick;
        rst = 1'b0; hard_rst = 1'b0;
        nc++; if ({rd_en, dread, dwrite, res_en, err} !== 7'd0) begin nm++; $display("FAIL reset_ctl got %b want 0", {rd_en, dread, dwrite, res_en, err}); end
        nc++; if ({daddr, wdata} !== 93'd0) begin nm++; $display("FAIL reset_addr_data got %h %h want 0", daddr, wdata); end
        nc++; if ({burst, be} !== {8'd1, 8'hFF}) begin nm++; $display("FAIL reset_burst_be got %h %h want 01 ff", burst, be); end
        nc++; if (res_dta !== 64'd0) begin nm++; $display("FAIL reset_res_dta got %h want 0", res_dta); end
        nc++; if (outs !== 4'd0) begin nm++; $display("FAIL reset_outstanding got %0d want 0", outs); end
    endtask

    task automatic test_write;
        int p0, wa;
        bit ok;
        p0 = pops[0]; wa = wr_acc; wreq = 1'b0;
        set_ch(0, 2'd3, 22'h123456, 64'hDEADBEEF);
        wait_en(0, ok);
        valid[0] = 1'b0;
        nc++; if (!ok) begin nm++; $display("FAIL write_grant got timeout want rd_en[0]"); end
        nc++; if (dwrite !== 1'b0) begin nm++; $display("FAIL write_early got %b want 0", dwrite); end
        tick;
        nc++; if ({dwrite, dread, daddr, wdata} !== {1'b1, 1'b0, 29'h06123456, 64'hDEADBEEF}) begin nm++; $display("FAIL write_cmd got w%b r%b %h %h want w1 r0 06123456 deadbeef", dwrite, dread, daddr, wdata); end
        tick;
        nc++; if (dwrite !== 1'b0) begin nm++; $display("FAIL write_one_cycle got %b want 0", dwrite); end
        repeat (5) tick;
        nc++; if (pops[0] - p0 !== 1) begin nm++; $display("FAIL write_pop_count got %0d want 1", pops[0] - p0); end
        nc++; if (wr_acc - wa !== 1) begin nm++; $display("FAIL write_accept_count got %0d want 1", wr_acc - wa); end
        wa = wr_acc; wreq = 1'b1;
        set_ch(1, 2'd3, 22'h3FFFFF, 64'h0123456789ABCDEF);
        wait_en(1, ok);
        valid[1] = 1'b0;
        tick; tick; tick; tick;
        nc++; if ({dwrite, daddr, wdata} !== {1'b1, 29'h063FFFFF, 64'h0123456789ABCDEF}) begin nm++; $display("FAIL write_hold got w%b %h %h want w1 063fffff 0123456789abcdef", dwrite, daddr, wdata); end
        wreq = 1'b0;
        tick;
        nc++; if (dwrite !== 1'b0 || wr_acc - wa !== 1) begin nm++; $display("FAIL write_release got w%b acc %0d want w0 acc 1", dwrite, wr_acc - wa); end
    endtask

    task automatic test_hazard;
        int p0, hi;
        bit ok;
        wreq = 1'b0;
        set_ch(1, 2'd2, 22'h155555, 64'd0);
        wait_en(1, ok);
        valid[1] = 1'b0;
        tick;
        nc++; if ({dread, daddr} !== {1'b1, 29'h06155555}) begin nm++; $display("FAIL hazard_read got r%b %h want r1 06155555", dread, daddr); end
        tick;
        nc++; if ({dread, outs} !== {1'b0, 4'd1}) begin nm++; $display("FAIL hazard_outstanding got r%b %0d want r0 1", dread, outs); end
        set_ch(0, 2'd3, 22'h000ABC, 64'h77);
        p0 = pops[0]; hi = 0;
        repeat (100) begin tick; if (dwrite) hi++; end
        nc++; if (hi !== 0 || pops[0] !== p0) begin nm++; $display("FAIL hazard_block got writes %0d pops %0d want 0 0", hi, pops[0] - p0); end
        rdata = 64'hCAFE; rdv = 1'b1;
        tick;
        rdv = 1'b0;
        nc++; if ({res_en, res_dta} !== {2'b10, 64'hCAFE}) begin nm++; $display("FAIL hazard_resp got %b %h want 10 cafe", res_en, res_dta); end
        nc++; if (outs !== 4'd0) begin nm++; $display("FAIL hazard_drain got %0d want 0", outs); end
        tick;
        nc++; if (res_en !== 2'b00) begin nm++; $display("FAIL hazard_resp_pulse got %b want 00", res_en); end
        wait_en(0, ok);
        valid[0] = 1'b0;
        tick;
        nc++; if (!ok || {dwrite, daddr} !== {1'b1, 29'h06000ABC}) begin nm++; $display("FAIL hazard_write_after got ok%b w%b %h want ok1 w1 06000abc", ok, dwrite, daddr); end
        tick;
    endtask

    task automatic test_soft_reset;
        int hi;
        bit ok;
        wreq = 1'b0;
        set_ch(1, 2'd2, 22'h000111, 64'd0);
        wait_en(1, ok);
        valid[1] = 1'b0;
        tick; tick;
        nc++; if (outs !== 4'd1) begin nm++; $display("FAIL soft_pre got %0d want 1", outs); end
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        nc++; if ({outs, dread, dwrite, rd_en} !== {4'd1, 4'd0}) begin nm++; $display("FAIL soft_survive got %0d %b%b%b want 1 000", outs, dread, dwrite, rd_en); end
        set_ch(0, 2'd3, 22'h000222, 64'h5A);
        hi = 0;
        repeat (20) begin tick; if (dwrite) hi++; end
        nc++; if (hi !== 0) begin nm++; $display("FAIL soft_write_block got %0d want 0", hi); end
        rdata = 64'h1234; rdv = 1'b1;
        tick;
        rdv = 1'b0;
        nc++; if ({res_en, res_dta} !== {2'b10, 64'h1234}) begin nm++; $display("FAIL soft_route got %b %h want 10 1234", res_en, res_dta); end
        wait_en(0, ok);
        valid[0] = 1'b0;
        tick;
        nc++; if (!ok || dwrite !== 1'b1) begin nm++; $display("FAIL soft_write_after got ok%b w%b want ok1 w1", ok, dwrite); end
        tick;
    endtask

    task automatic test_abort;
        int ra;
        bit ok;
        wreq = 1'b1;
        set_ch(0, 2'd2, 22'h000003, 64'd0);
        wait_en(0, ok);
        valid[0] = 1'b0;
        tick;
        nc++; if (dread !== 1'b1) begin nm++; $display("FAIL abort_pending got %b want 1", dread); end
        ra = rd_acc; rst = 1'b1;
        tick;
        rst = 1'b0;
        nc++; if (dread !== 1'b0) begin nm++; $display("FAIL abort_drop got %b want 0", dread); end
        wreq = 1'b0;
        repeat (5) tick;
        nc++; if (outs !== 4'd0 || rd_acc !== ra) begin nm++; $display("FAIL abort_uncounted got %0d acc %0d want 0 0", outs, rd_acc - ra); end
    endtask

    task automatic test_max_out;
        int g0, g1;
        bit ord;
        hard_rst = 1'b1;
        tick;
        hard_rst = 1'b0; wreq = 1'b0;
        g0 = gr_n;
        set_ch(0, 2'd2, 22'h000010, 64'd0);
        set_ch(1, 2'd2, 22'h000020, 64'd0);
        repeat (40) tick;
        nc++; if (gr_n - g0 !== 8 || outs !== 4'd8) begin nm++; $display("FAIL max_fill got grants %0d out %0d want 8 8", gr_n - g0, outs); end
        ord = 1'b1;
        for (int k = 0; k < 8; k++) if (gr_log[g0 + k] != k % 2) ord = 1'b0;
        nc++; if (!ord) begin nm++; $display("FAIL max_order got %0d%0d%0d%0d want 0101", gr_log[g0], gr_log[g0+1], gr_log[g0+2], gr_log[g0+3]); end
        g1 = gr_n;
        repeat (10) tick;
        nc++; if (gr_n !== g1) begin nm++; $display("FAIL max_stall got %0d extra grants want 0", gr_n - g1); end
        rdata = 64'hA0; rdv = 1'b1;
        tick;
        rdv = 1'b0;
        nc++; if (res_en !== 2'b01) begin nm++; $display("FAIL max_first_resp got %b want 01", res_en); end
        repeat (15) tick;
        nc++; if (gr_n - g0 !== 9 || outs !== 4'd8 || gr_log[g0 + 8] !== 0) begin nm++; $display("FAIL max_release got grants %0d out %0d want 9 8", gr_n - g0, outs); end
        valid = 2'b00;
        for (int k = 0; k < 8; k++) begin
            rdata = 64'(k); rdv = 1'b1;
            tick;
            rdv = 1'b0;
            nc++; if (res_en !== (k % 2 == 0 ? 2'b10 : 2'b01)) begin nm++; $display("FAIL max_drain_%0d got %b want %b", k, res_en, (k % 2 == 0 ? 2'b10 : 2'b01)); end
        end
        tick;
        nc++; if (outs !== 4'd0) begin nm++; $display("FAIL max_empty got %0d want 0", outs); end
    endtask

    task automatic test_almost_full;
        int p0;
        bit ok;
        wreq = 1'b0; af = 2'b01; p0 = pops[0];
        set_ch(0, 2'd2, 22'h000030, 64'd0);
        set_ch(1, 2'd3, 22'h000040, 64'h99);
        wait_en(1, ok);
        valid[1] = 1'b0;
        nc++; if (!ok || rd_en !== 2'b10) begin nm++; $display("FAIL af_grant got ok%b %b want ok1 10", ok, rd_en); end
        repeat (10) tick;
        nc++; if (pops[0] !== p0) begin nm++; $display("FAIL af_block got %0d pops want 0", pops[0] - p0); end
        af = 2'b00;
        wait_en(0, ok);
        valid[0] = 1'b0;
        tick; tick;
        nc++; if (!ok || outs !== 4'd1) begin nm++; $display("FAIL af_release got ok%b out %0d want ok1 1", ok, outs); end
        rdata = 64'h55; rdv = 1'b1;
        tick;
        rdv = 1'b0;
        nc++; if ({res_en, res_dta} !== {2'b01, 64'h55}) begin nm++; $display("FAIL af_resp got %b %h want 01 55", res_en, res_dta); end
    endtask

    task automatic test_unexpected;
        tick;
        rdata = 64'h99; rdv = 1'b1;
        tick;
        rdv = 1'b0;
        nc++; if ({err, res_en, outs} !== {1'b1, 2'b00, 4'd0}) begin nm++; $display("FAIL unexp_flag got e%b %b %0d want e1 00 0", err, res_en, outs); end
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        nc++; if (err !== 1'b1) begin nm++; $display("FAIL unexp_sticky got %b want 1", err); end
        hard_rst = 1'b1;
        tick;
        hard_rst = 1'b0;
        nc++; if (err !== 1'b0) begin nm++; $display("FAIL unexp_hard_clear got %b want 0", err); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_hazard;
        test_soft_reset;
        test_abort;
        test_max_out;
        test_almost_full;
        test_unexpected;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nm);
        $finish;
    end
endmodule
